// File: rtl/garegga_snd_rom_arb.sv
// ---------------------------------------------------------------------------
// garegga_snd_rom_arb
//
// Sound-ROM arbiter for the Garegga-family sound subsystem. Two requesters
// share one SDRAM read port:
//   - Z80 program fetch (17-bit banked byte address)
//   - OKI/NMK112 ADPCM fetch (20-bit translated byte address)
// Each requester has a one-entry data latch (tag/data/valid). A read whose
// address matches the latched tag completes combinationally, with no SDRAM
// traffic. A missing read is forwarded to SDRAM. When both requesters miss
// together, the grant alternates between them.
//
// Ports
//   CLK96      in   1   system clock, rising edge
//   RESET96_N  in   1   synchronous active-low reset
//   Z80_CS     in   1   Z80 ROM read request (level)
//   Z80_ADDR   in  17   Z80 ROM byte address
//   Z80_OK     out  1   Z80_DOUT valid for current Z80_ADDR
//   Z80_DOUT   out  8   Z80 ROM data (latched)
//   PCM_CS     in   1   ADPCM read request (level)
//   PCM_ADDR   in  20   ADPCM byte address
//   PCM_OK     out  1   PCM_DOUT valid for current PCM_ADDR
//   PCM_DOUT   out  8   ADPCM data (latched)
//   MEM_REQ    out  1   SDRAM read request, held until MEM_RDY
//   MEM_ADDR   out 22   SDRAM byte address, stable while MEM_REQ=1
//   MEM_RDY    in   1   one-cycle pulse, MEM_DATA valid
//   MEM_DATA   in   8   SDRAM read data
//
// FSM states
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | no access in flight; arbitrate pending misses
//   ST_BUSY_Z80 | SDRAM read in flight for the Z80 channel
//   ST_BUSY_PCM | SDRAM read in flight for the ADPCM channel
// ---------------------------------------------------------------------------
module garegga_snd_rom_arb #(
  parameter logic [21:0] Z80_BASE = 22'h000000,
  parameter logic [21:0] PCM_BASE = 22'h040000
) (
  input  logic        CLK96,
  input  logic        RESET96_N,

  input  logic        Z80_CS,
  input  logic [16:0] Z80_ADDR,
  output logic        Z80_OK,
  output logic [7:0]  Z80_DOUT,

  input  logic        PCM_CS,
  input  logic [19:0] PCM_ADDR,
  output logic        PCM_OK,
  output logic [7:0]  PCM_DOUT,

  output logic        MEM_REQ,
  output logic [21:0] MEM_ADDR,
  input  logic        MEM_RDY,
  input  logic [7:0]  MEM_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_Z80 = 2'd1,
    ST_BUSY_PCM = 2'd2
  } state_t;

  // Round-robin memory: which channel received the most recent grant.
  localparam logic LAST_Z80 = 1'b0;
  localparam logic LAST_PCM = 1'b1;

  state_t      state_q;
  state_t      state_d;

  logic [16:0] z80_tag_q;
  logic [7:0]  z80_data_q;
  logic        z80_vld_q;
  logic [19:0] pcm_tag_q;
  logic [7:0]  pcm_data_q;
  logic        pcm_vld_q;

  logic [19:0] fl_addr_q;
  logic        last_q;
  logic [21:0] mem_addr_q;

  logic        z80_hit;
  logic        pcm_hit;
  logic        z80_pend;
  logic        pcm_pend;
  logic        grant_z80;
  logic        grant_pcm;
  logic        fill_z80;
  logic        fill_pcm;

  // -------------------------------------------------------------------------
  // Latch hit / pending detection
  // -------------------------------------------------------------------------
  always_comb begin
    z80_hit  = z80_vld_q && (Z80_ADDR == z80_tag_q);
    pcm_hit  = pcm_vld_q && (PCM_ADDR == pcm_tag_q);
    z80_pend = Z80_CS && !z80_hit;
    pcm_pend = PCM_CS && !pcm_hit;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state and grant decision
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_z80 = 1'b0;
    grant_pcm = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (z80_pend && pcm_pend) begin
          // Tie: the channel that did not win last time goes first.
          if (last_q == LAST_PCM) begin
            grant_z80 = 1'b1;
          end else begin
            grant_pcm = 1'b1;
          end
        end else if (z80_pend) begin
          grant_z80 = 1'b1;
        end else if (pcm_pend) begin
          grant_pcm = 1'b1;
        end

        if (grant_z80) begin
          state_d = ST_BUSY_Z80;
        end else if (grant_pcm) begin
          state_d = ST_BUSY_PCM;
        end
      end
      ST_BUSY_Z80: begin
        if (MEM_RDY) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_PCM: begin
        if (MEM_RDY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // MEM_REQ is high exactly while an access is in flight, so it is decoded
  // from the state rather than kept in its own flop. Returning to IDLE on
  // MEM_RDY guarantees at least one low cycle between requests.
  // -------------------------------------------------------------------------
  always_comb begin
    MEM_REQ  = (state_q != ST_IDLE);
    MEM_ADDR = mem_addr_q;
    fill_z80 = (state_q == ST_BUSY_Z80) && MEM_RDY;
    fill_pcm = (state_q == ST_BUSY_PCM) && MEM_RDY;
    Z80_OK   = Z80_CS && z80_hit;
    PCM_OK   = PCM_CS && pcm_hit;
    Z80_DOUT = z80_data_q;
    PCM_DOUT = pcm_data_q;
  end

  // -------------------------------------------------------------------------
  // Datapath: request address, flight address, latches
  // The returned byte is tagged with the address captured at grant time, not
  // the requester's current address, so a requester that moved on during the
  // flight sees a miss and re-requests.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      mem_addr_q <= 22'd0;
      fl_addr_q  <= 20'd0;
      last_q     <= LAST_PCM;
      z80_tag_q  <= 17'd0;
      z80_data_q <= 8'd0;
      z80_vld_q  <= 1'b0;
      pcm_tag_q  <= 20'd0;
      pcm_data_q <= 8'd0;
      pcm_vld_q  <= 1'b0;
    end else begin
      if (grant_z80) begin
        mem_addr_q <= Z80_BASE + {5'd0, Z80_ADDR};
        fl_addr_q  <= {3'd0, Z80_ADDR};
        last_q     <= LAST_Z80;
      end else if (grant_pcm) begin
        mem_addr_q <= PCM_BASE + {2'd0, PCM_ADDR};
        fl_addr_q  <= PCM_ADDR;
        last_q     <= LAST_PCM;
      end

      if (fill_z80) begin
        z80_data_q <= MEM_DATA;
        z80_tag_q  <= fl_addr_q[16:0];
        z80_vld_q  <= 1'b1;
      end

      if (fill_pcm) begin
        pcm_data_q <= MEM_DATA;
        pcm_tag_q  <= fl_addr_q;
        pcm_vld_q  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/garegga_snd_rom_arb.md
# garegga_snd_rom_arb

Sound-ROM arbiter for the Garegga-family sound subsystem. It shares one SDRAM read port between the Z80 program fetch path (17-bit banked address) and the OKI/NMK112 ADPCM fetch path (20-bit address). It keeps a one-entry data latch per requester, so repeated reads of the same address complete without an SDRAM access. It sits between `garegga_sound` (ROMZ80_*/PCM_* buses) and the board SDRAM controller slot.

## Interface
Parameters:
- `Z80_BASE`, 22'h000000, byte offset of Z80 program ROM in SDRAM.
- `PCM_BASE`, 22'h040000, byte offset of ADPCM ROM in SDRAM.

Ports:
- `CLK96`  in  1  system clock; all logic on its rising edge.
- `RESET96_N`  in  1  synchronous, active-low reset.
- `Z80_CS`  in  1  Z80 ROM read request (level).
- `Z80_ADDR`  in  17  Z80 ROM byte address (bank already applied).
- `Z80_OK`  out  1  Z80_DOUT valid for current Z80_ADDR.
- `Z80_DOUT`  out  8  Z80 ROM data.
- `PCM_CS`  in  1  ADPCM read request (level).
- `PCM_ADDR`  in  20  ADPCM byte address (NMK112-translated).
- `PCM_OK`  out  1  PCM_DOUT valid for current PCM_ADDR.
- `PCM_DOUT`  out  8  ADPCM data.
- `MEM_REQ`  out  1  SDRAM read request, held until MEM_RDY.
- `MEM_ADDR`  out  22  SDRAM byte address, stable while MEM_REQ=1.
- `MEM_RDY`  in  1  one-cycle pulse: MEM_DATA valid for the outstanding request.
- `MEM_DATA`  in  8  SDRAM read data.

## Operation
- Per channel c∈{Z80,PCM}: registers `c_tag` (address), `c_data` (8b), `c_vld` (1b).
- `c_hit` = `c_vld` && `c_ADDR`==`c_tag`. `c_OK` = `c_CS` && `c_hit` (combinational). `c_DOUT` = `c_data`.
- `c_pend` = `c_CS` && !`c_hit`.
- FSM states: IDLE, BUSY_Z80, BUSY_PCM.
  - IDLE, one channel pending: grant it.
  - IDLE, both pending: grant the channel not in `last` (round robin). `last` resets to PCM, so Z80 wins the first tie.
  - On grant: MEM_REQ<=1; MEM_ADDR<=base+zero-extended address (22-bit, wrap modulo 2^22); `fl_addr`<=requested address; `last`<=granted channel; go to BUSY_x.
  - BUSY_x, MEM_RDY=1: `x_data`<=MEM_DATA; `x_tag`<=`fl_addr`; `x_vld`<=1; MEM_REQ<=0; go to IDLE.
  - BUSY_x, MEM_RDY=0: hold MEM_REQ and MEM_ADDR; ignore requester changes.
- Requester address change during flight: the returned data is stored under `fl_addr`, so OK stays low (tag mismatch). A new request issues from IDLE.
- CS deassertion does not clear `c_vld` (data latch persists).
- MEM_RDY in IDLE is ignored; no state change.
- No request cancellation: a granted access always completes.

## Timing
- Reset values: MEM_REQ=0, MEM_ADDR=0, Z80_DOUT=0, PCM_DOUT=0, Z80_OK=0, PCM_OK=0, both `c_vld`=0, state IDLE, `last`=PCM.
- Miss latency: pending seen in cycle n → MEM_REQ=1 at n+1 → MEM_RDY in cycle m → c_OK=1 and data at m+1.
- Hit latency: 0 cycles (OK the same cycle the address matches).
- At least one IDLE cycle between consecutive SDRAM requests; MEM_REQ is low for ≥1 cycle after each MEM_RDY.
- Reset mid-flight (RESET96_N=0 while BUSY): next cycle all state is at reset values. A MEM_RDY arriving after reset is ignored.
- Worst-case wait for a channel with both contending: one foreign access plus its own.

## Test plan
- Reset release, Z80_CS=1, Z80_ADDR=17'h00100 → MEM_REQ=1, MEM_ADDR=22'h000100 next cycle. MEM_RDY with MEM_DATA=8'h3E → Z80_OK=1, Z80_DOUT=8'h3E one cycle later; MEM_REQ=0.
- Repeat read of Z80_ADDR=17'h00100 after CS toggle → Z80_OK=1 in same cycle, MEM_REQ stays 0.
- Z80 and PCM (PCM_ADDR=20'h12345) pending together from reset → Z80 granted first. After its RDY, MEM_ADDR=22'h052345 for PCM; alternation holds over 8 contended misses (Z80,PCM,Z80,…).
- PCM_ADDR changes 20'h00010→20'h00011 while BUSY_PCM; RDY data 8'hA5 → PCM_OK stays 0, tag=20'h00010. A second request at 22'h040011 issues after one IDLE cycle.
- RESET96_N low for 1 cycle during BUSY_Z80, then MEM_RDY pulse → MEM_REQ=0, Z80_OK=0, no latch update. A fresh request reissues normally.
- MEM_RDY pulsed in IDLE with no CS → no output change, MEM_REQ remains 0.
